sprite_blitter: RTL and testbench

- Writer side of the sprite/framebuffer memory interface.
- On a start pulse, copies a width x height rectangle of 8-bit RGB332 pixels from a sprite ROM into a framebuffer RAM at screen position (x0, y0).
- The framebuffer is row-major, FB_WIDTH pixels per row, and is later scanned by the VGA-side sprite readers.
- Sits between the game/control logic and the framebuffer write port. Write backpressure lets the framebuffer arbiter favour display reads.

---
 rtl/sprite_blitter_if.sv | 33 +++
 rtl/sprite_blitter.sv | 165 ++++++++++++++++
 tb/tb_sprite_blitter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_blitter_if.sv
// Bus bundle between the sprite blitter and its environment: control/request, sprite ROM
// read port, framebuffer write port with backpressure, and status.
interface sprite_blitter_if #(
  parameter int unsigned FB_ADDR_W  = 19,
  parameter int unsigned SRC_ADDR_W = 15
);
  logic                  start;
  logic [10:0]           x0;
  logic [10:0]           y0;
  logic [9:0]            width;
  logic [9:0]            height;
  logic [SRC_ADDR_W-1:0] src_base;
  logic [SRC_ADDR_W-1:0] src_addr;
  logic [7:0]            src_data;
  logic                  fb_we;
  logic [FB_ADDR_W-1:0]  fb_addr;
  logic [7:0]            fb_wdata;
  logic                  fb_ready;
  logic                  busy;
  logic                  done;

  // Environment side: issues requests, models the ROM, arbitrates framebuffer writes.
  modport master (
    output start, x0, y0, width, height, src_base, src_data, fb_ready,
    input  src_addr, fb_we, fb_addr, fb_wdata, busy, done
  );

  // Blitter side.
  modport slave (
    input  start, x0, y0, width, height, src_base, src_data, fb_ready,
    output src_addr, fb_we, fb_addr, fb_wdata, busy, done
  );
endinterface

// File: rtl/sprite_blitter.sv
// Copies a width x height RGB332 sprite from ROM into the row-major framebuffer at (x0, y0),
// clipping off-screen pixels. Define SPRITE_BLITTER_TRANSPARENCY_EN to also skip 8'h00 pixels.
module sprite_blitter #(
  parameter int unsigned FB_WIDTH   = 640,
  parameter int unsigned FB_HEIGHT  = 480,
  parameter int unsigned FB_ADDR_W  = 19,
  parameter int unsigned SRC_ADDR_W = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  sprite_blitter_if.slave bus
);

  localparam int unsigned COORD_W = 11;
  localparam int unsigned DIM_W   = 10;
  localparam int unsigned DX_W    = 12;
  localparam int unsigned PIX_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CAPT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [COORD_W-1:0]    x0_q, x0_d, y0_q, y0_d;
  logic [DIM_W-1:0]      w_q, w_d, h_q, h_d;
  logic [DIM_W-1:0]      col_q, col_d, row_q, row_d;
  logic [SRC_ADDR_W-1:0] src_ptr_q, src_ptr_d;
  logic [FB_ADDR_W-1:0]  row_base_q, row_base_d;
  logic [PIX_W-1:0]      pix_q, pix_d;
  logic [FB_ADDR_W-1:0]  fb_addr_q, fb_addr_d;
  logic                  fb_we_q, fb_we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [DX_W-1:0] dx_c, dy_c;
  logic            clip_c, key_c, skip_c;
  logic            last_col_c, last_pix_c;
  logic            load_c, accept_c, advance_c, empty_c;

  // Destination coordinates carry a spare bit so a far-right sprite never wraps back on-screen.
  assign dx_c   = DX_W'(x0_q) + DX_W'(col_q);
  assign dy_c   = DX_W'(y0_q) + DX_W'(row_q);
  assign clip_c = (dx_c >= DX_W'(FB_WIDTH)) || (dy_c >= DX_W'(FB_HEIGHT));

`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
  assign key_c = (bus.src_data == PIX_W'(0));
`else
  assign key_c = 1'b0;
`endif

  assign skip_c     = clip_c || key_c;
  assign last_col_c = (col_q == w_q - DIM_W'(1));
  assign last_pix_c = last_col_c && (row_q == h_q - DIM_W'(1));
  assign load_c     = (state_q == S_IDLE) && bus.start;
  assign empty_c    = (bus.width == DIM_W'(0)) || (bus.height == DIM_W'(0));
  assign accept_c   = (state_q == S_WRITE) && bus.fb_ready;
  assign advance_c  = ((state_q == S_CAPT) && skip_c) || accept_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = empty_c ? S_DONE : S_READ;
      S_READ:  state_d = S_CAPT;
      S_CAPT:  if (skip_c) state_d = last_pix_c ? S_DONE : S_READ;
               else        state_d = S_WRITE;
      S_WRITE: if (bus.fb_ready) state_d = last_pix_c ? S_DONE : S_READ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: flags follow the upcoming state so they line up with it after the edge.
  always_comb begin
    fb_we_d   = (state_d == S_WRITE);
    busy_d    = (state_d == S_READ) || (state_d == S_CAPT) || (state_d == S_WRITE);
    done_d    = (state_d == S_DONE);
    fb_addr_d = fb_addr_q;
    if ((state_q == S_CAPT) && !skip_c) fb_addr_d = row_base_q + FB_ADDR_W'(dx_c);
  end

  // Request latch and raster walk; row_base avoids a multiply per pixel.
  always_comb begin
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    col_d      = col_q;
    row_d      = row_q;
    src_ptr_d  = src_ptr_q;
    row_base_d = row_base_q;
    pix_d      = pix_q;
    if (load_c) begin
      x0_d       = bus.x0;
      y0_d       = bus.y0;
      w_d        = bus.width;
      h_d        = bus.height;
      col_d      = '0;
      row_d      = '0;
      src_ptr_d  = bus.src_base;
      row_base_d = FB_ADDR_W'(32'(bus.y0) * FB_WIDTH);
    end else if (advance_c) begin
      src_ptr_d = src_ptr_q + SRC_ADDR_W'(1);
      if (last_col_c) begin
        col_d      = '0;
        row_d      = row_q + DIM_W'(1);
        row_base_d = row_base_q + FB_ADDR_W'(FB_WIDTH);
      end else begin
        col_d = col_q + DIM_W'(1);
      end
    end
    if (state_q == S_CAPT) pix_d = bus.src_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      col_q      <= '0;
      row_q      <= '0;
      src_ptr_q  <= '0;
      row_base_q <= '0;
      pix_q      <= '0;
      fb_addr_q  <= '0;
      fb_we_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      w_q        <= w_d;
      h_q        <= h_d;
      col_q      <= col_d;
      row_q      <= row_d;
      src_ptr_q  <= src_ptr_d;
      row_base_q <= row_base_d;
      pix_q      <= pix_d;
      fb_addr_q  <= fb_addr_d;
      fb_we_q    <= fb_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.src_addr = src_ptr_q;
  assign bus.fb_we    = fb_we_q;
  assign bus.fb_addr  = fb_addr_q;
  assign bus.fb_wdata = pix_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: a reference raster model fills a write scoreboard that
// the framebuffer-port monitor drains and checks, plus latency/status checks.
module tb_sprite_blitter;

  localparam int unsigned FB_WIDTH   = 640;
  localparam int unsigned FB_HEIGHT  = 480;
  localparam int unsigned FB_ADDR_W  = 19;
  localparam int unsigned SRC_ADDR_W = 15;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [7:0]           data;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sprite_blitter_if #(.FB_ADDR_W(FB_ADDR_W), .SRC_ADDR_W(SRC_ADDR_W)) bif ();

  sprite_blitter #(
    .FB_WIDTH  (FB_WIDTH),
    .FB_HEIGHT (FB_HEIGHT),
    .FB_ADDR_W (FB_ADDR_W),
    .SRC_ADDR_W(SRC_ADDR_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  always #5 clk = ~clk;

  wr_t sb[$];
  int  checks       = 0;
  int  errors       = 0;
  int  cyc          = 0;
  int  wr_cnt       = 0;
  int  done_cnt     = 0;
  int  stall_cnt    = 0;
  int  first_we_cyc = -1;
  int  last_wr_cyc  = 0;
  int  done_cyc     = 0;
  int  zero_addr    = -1;
  int  sc           = 0;
  int  wr0, d0, n;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rom_val(input logic [SRC_ADDR_W-1:0] a);
    if (int'(a) == zero_addr) return 8'h00;
    return a[7:0];
  endfunction

  // Synchronous sprite ROM: data for src_addr appears one cycle later.
  always @(posedge clk) bif.src_data <= rom_val(bif.src_addr);

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Framebuffer port monitor; also checks address/data hold during stalls.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bif.fb_we && first_we_cyc < 0) first_we_cyc = cyc;
      if (bif.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bif.fb_we) begin
        if (sb.size() == 0) begin
          chk("unexpected_write_addr", int'(bif.fb_addr), -1);
        end else begin
          chk("wr_addr", int'(bif.fb_addr), int'(sb[0].addr));
          chk("wr_data", int'(bif.fb_wdata), int'(sb[0].data));
        end
        if (bif.fb_ready) begin
          if (sb.size() != 0) void'(sb.pop_front());
          wr_cnt++;
          last_wr_cyc = cyc;
        end else begin
          stall_cnt++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_expected(input int x, input int y, input int w, input int h, input int base);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        int dx = x + c;
        int dy = y + r;
        logic [7:0] d = rom_val(SRC_ADDR_W'(base + r * w + c));
        wr_t e;
        if (dx < int'(FB_WIDTH) && dy < int'(FB_HEIGHT)) begin
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
          if (d != 8'h00) begin
`else
          begin
`endif
            e.addr = FB_ADDR_W'(dy * int'(FB_WIDTH) + dx);
            e.data = d;
            sb.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic start_copy(input int x, input int y, input int w, input int h, input int base);
    bif.x0       = 11'(x);
    bif.y0       = 11'(y);
    bif.width    = 10'(w);
    bif.height   = 10'(h);
    bif.src_base = SRC_ADDR_W'(base);
    push_expected(x, y, w, h, base);
    first_we_cyc = -1;
    bif.start    = 1'b1;
    sc           = cyc;
    step();
    bif.start    = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    int d = done_cnt;
    while (done_cnt == d && k < budget) begin
      step();
      k++;
    end
    chk("done_timeout", int'(done_cnt != d), 1);
  endtask

  task automatic wait_we(input logic level, input int budget);
    int k = 0;
    while (bif.fb_we !== level && k < budget) begin
      step();
      k++;
    end
    chk("fb_we_timeout", int'(bif.fb_we), int'(level));
  endtask

  initial begin
    bif.start    = 1'b0;
    bif.x0       = '0;
    bif.y0       = '0;
    bif.width    = '0;
    bif.height   = '0;
    bif.src_base = '0;
    bif.fb_ready = 1'b1;
    repeat (3) step();

    // Reset state
    chk("rst_fb_we", int'(bif.fb_we), 0);
    chk("rst_busy", int'(bif.busy), 0);
    chk("rst_done", int'(bif.done), 0);
    chk("rst_src_addr", int'(bif.src_addr), 0);
    chk("rst_fb_addr", int'(bif.fb_addr), 0);
    chk("rst_fb_wdata", int'(bif.fb_wdata), 0);
    rst_n = 1'b1;
    step();

    // Basic copy: 1290..1292, 1930..1932 with data 100..105
    wr0 = wr_cnt;
    d0  = done_cnt;
    start_copy(10, 2, 3, 2, 100);
    chk("busy_after_start", int'(bif.busy), 1);
    chk("first_sb_addr", int'(sb[0].addr), 1290);
    wait_done(100);
    chk("basic_writes", wr_cnt - wr0, 6);
    chk("basic_latency", first_we_cyc - sc, 3);
    chk("basic_done_after_last", done_cyc - last_wr_cyc, 1);
    repeat (3) step();
    chk("basic_done_once", done_cnt - d0, 1);
    chk("basic_busy_idle", int'(bif.busy), 0);
    chk("basic_sb_empty", sb.size(), 0);

    // Backpressure: 4 stalled cycles on the 2nd write
    wr0       = wr_cnt;
    stall_cnt = 0;
    start_copy(10, 2, 3, 2, 100);
    wait_we(1'b1, 20);
    step();
    step();
    bif.fb_ready = 1'b0;
    repeat (5) step();
    chk("bp_addr_held", int'(bif.fb_addr), 1291);
    chk("bp_data_held", int'(bif.fb_wdata), 101);
    bif.fb_ready = 1'b1;
    wait_done(100);
    chk("bp_stalls", stall_cnt, 4);
    chk("bp_writes", wr_cnt - wr0, 6);
    chk("bp_sb_empty", sb.size(), 0);

    // Clipping at the bottom-right corner
    wr0 = wr_cnt;
    start_copy(638, 479, 4, 2, 0);
    chk("clip_model_addr", int'(sb[1].addr), 307199);
    wait_done(100);
    chk("clip_writes", wr_cnt - wr0, 2);
    chk("clip_sb_empty", sb.size(), 0);

    // Transparency key at sprite column 1
    wr0       = wr_cnt;
    zero_addr = 201;
    start_copy(0, 0, 3, 1, 200);
    wait_done(100);
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
    chk("transp_writes", wr_cnt - wr0, 2);
`else
    chk("transp_writes", wr_cnt - wr0, 3);
`endif
    chk("transp_sb_empty", sb.size(), 0);
    zero_addr = -1;

    // Degenerate width = 0
    wr0 = wr_cnt;
    start_copy(5, 5, 0, 4, 0);
    wait_done(20);
    chk("zero_w_done_latency", done_cyc - sc, 1);
    chk("zero_w_writes", wr_cnt - wr0, 0);

    // Start while busy and input changes after acceptance are ignored
    wr0 = wr_cnt;
    start_copy(10, 2, 3, 2, 100);
    repeat (3) step();
    bif.x0       = 11'd0;
    bif.y0       = 11'd0;
    bif.width    = 10'd1;
    bif.height   = 10'd1;
    bif.src_base = SRC_ADDR_W'(7);
    bif.start    = 1'b1;
    step();
    bif.start    = 1'b0;
    wait_done(100);
    repeat (6) step();
    chk("busy_start_writes", wr_cnt - wr0, 6);
    chk("busy_start_sb_empty", sb.size(), 0);
    chk("busy_start_idle", int'(bif.busy), 0);

    // Reset during the 2nd write, then a full copy
    start_copy(20, 5, 3, 2, 300);
    wait_we(1'b1, 20);
    step();
    wait_we(1'b0, 20);
    wait_we(1'b1, 20);
    rst_n = 1'b0;
    #1;
    chk("midrst_fb_we", int'(bif.fb_we), 0);
    chk("midrst_busy", int'(bif.busy), 0);
    chk("midrst_done", int'(bif.done), 0);
    chk("midrst_src_addr", int'(bif.src_addr), 0);
    sb.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    wr0 = wr_cnt;
    start_copy(20, 5, 3, 2, 300);
    wait_done(100);
    chk("post_rst_writes", wr_cnt - wr0, 6);
    chk("post_rst_latency", first_we_cyc - sc, 3);
    chk("post_rst_sb_empty", sb.size(), 0);

    n = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
